uart_rx_core: RTL and testbench

//  Synthesizable UART receiver: 16x-oversampled, 5-8 data bits, optional parity, 1/2 stop bits.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_core.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned OVS        = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned PHASE_W    = $clog2(OVS);

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP1  = 3'd4,
    RX_STOP2  = 3'd5
  } rx_state_e;

  // Index of the final data bit for a data-bits encoding.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    logic [2:0] idx;
    case (data_bits)
      DATA_BITS_5: idx = 3'd4;
      DATA_BITS_6: idx = 3'd5;
      DATA_BITS_7: idx = 3'd6;
      DATA_BITS_8: idx = 3'd7;
      default:     idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: one tick every divisor+1 clocks, restartable.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..divisor, pulse on wrap; clear holds the phase at zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == divisor) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter and tick registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// 16x oversampled UART receiver with valid/ready output and error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             rx_en,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_stop_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_even_parity,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic             rxd,
  output logic [7:0]       rx_data,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ovr,
  output logic             rx_busy
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_prev_q, rxd_prev_d;
  rx_state_e              state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_acc_q, par_acc_d;
  logic                   frm_acc_q, frm_acc_d;
  logic [1:0]             f_bits_q, f_bits_d;
  logic                   f_stop_q, f_stop_d;
  logic                   f_par_en_q, f_par_en_d;
  logic                   f_even_q, f_even_d;
  logic [DIV_W-1:0]       f_div_q, f_div_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_par_err_q, rx_par_err_d;
  logic                   rx_frm_err_q, rx_frm_err_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_ovr_q, rx_ovr_d;
  logic                   rx_busy_q, rx_busy_d;

  logic rxd_s, start_edge, tick, sample, done, done_frm;

  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign start_edge = rxd_prev_q & ~rxd_s;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .mclk    (mclk),
    .reset   (reset),
    .clear   (state_q == RX_IDLE),
    .divisor (f_div_q),
    .tick    (tick)
  );

  // Frame sequencing, bit assembly and output handshake.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], rxd};
    rxd_prev_d   = rxd_s;
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_acc_d    = par_acc_q;
    frm_acc_d    = frm_acc_q;
    f_bits_d     = f_bits_q;
    f_stop_d     = f_stop_q;
    f_par_en_d   = f_par_en_q;
    f_even_d     = f_even_q;
    f_div_d      = f_div_q;
    rx_data_d    = rx_data_q;
    rx_par_err_d = rx_par_err_q;
    rx_frm_err_d = rx_frm_err_q;
    rx_valid_d   = rx_valid_q;
    rx_ovr_d     = 1'b0;
    done         = 1'b0;
    done_frm     = frm_acc_q;

    // Start bit is sampled at its midpoint, later bits one full bit apart.
    if (state_q == RX_START) begin
      sample = tick && (phase_q == PHASE_W'(MID_SAMPLE - 1));
    end else begin
      sample = tick && (phase_q == PHASE_W'(OVS - 1));
    end
    if (tick) begin
      phase_d = (sample && state_q == RX_START) ? '0 : phase_q + PHASE_W'(1);
    end

    case (state_q)
      RX_IDLE: begin
        phase_d = '0;
        if (rx_en && start_edge) begin
          state_d    = RX_START;
          bit_cnt_d  = '0;
          shreg_d    = '0;
          par_acc_d  = 1'b0;
          frm_acc_d  = 1'b0;
          f_bits_d   = cfg_data_bits;
          f_stop_d   = cfg_stop_bits;
          f_par_en_d = cfg_parity_en;
          f_even_d   = cfg_even_parity;
          f_div_d    = cfg_divisor;
        end
      end
      RX_START: begin
        if (sample) state_d = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (sample) begin
          shreg_d[bit_cnt_q] = rxd_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == last_bit_idx(f_bits_q)) begin
            state_d = f_par_en_q ? RX_PARITY : RX_STOP1;
          end
        end
      end
      RX_PARITY: begin
        if (sample) begin
          par_acc_d = (^shreg_q) ^ rxd_s ^ ~f_even_q;
          state_d   = RX_STOP1;
        end
      end
      RX_STOP1: begin
        if (sample) begin
          if (f_stop_q) begin
            frm_acc_d = ~rxd_s;
            state_d   = RX_STOP2;
          end else begin
            done     = 1'b1;
            done_frm = ~rxd_s;
            state_d  = RX_IDLE;
          end
        end
      end
      RX_STOP2: begin
        if (sample) begin
          done     = 1'b1;
          done_frm = frm_acc_q | ~rxd_s;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Disabling the receiver discards any frame in flight.
    if (state_q != RX_IDLE && !rx_en) begin
      state_d = RX_IDLE;
      done    = 1'b0;
    end

    // Load a finished frame unless an unconsumed word is still held.
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        rx_par_err_d = f_par_en_q & par_acc_q;
        rx_frm_err_d = done_frm;
        rx_valid_d   = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    rx_busy_d = (state_d != RX_IDLE);
  end

  // All state, synchroniser and output registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      sync_q       <= '1;
      rxd_prev_q   <= 1'b1;
      state_q      <= RX_IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      frm_acc_q    <= 1'b0;
      f_bits_q     <= '0;
      f_stop_q     <= 1'b0;
      f_par_en_q   <= 1'b0;
      f_even_q     <= 1'b0;
      f_div_q      <= '0;
      rx_data_q    <= '0;
      rx_par_err_q <= 1'b0;
      rx_frm_err_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_ovr_q     <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rxd_prev_q   <= rxd_prev_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_acc_q    <= par_acc_d;
      frm_acc_q    <= frm_acc_d;
      f_bits_q     <= f_bits_d;
      f_stop_q     <= f_stop_d;
      f_par_en_q   <= f_par_en_d;
      f_even_q     <= f_even_d;
      f_div_q      <= f_div_d;
      rx_data_q    <= rx_data_d;
      rx_par_err_q <= rx_par_err_d;
      rx_frm_err_q <= rx_frm_err_d;
      rx_valid_q   <= rx_valid_d;
      rx_ovr_q     <= rx_ovr_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_par_err = rx_par_err_q;
  assign rx_frm_err = rx_frm_err_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ovr     = rx_ovr_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Randomised frame-level bench for uart_rx_core against a serial-frame model.
module tb_uart_rx_core;

  localparam int unsigned DIV_W = 16;

  logic             mclk = 1'b0;
  logic             reset, rx_en, rxd, rx_ready;
  logic [1:0]       cfg_data_bits;
  logic             cfg_stop_bits, cfg_parity_en, cfg_even_parity;
  logic [DIV_W-1:0] cfg_divisor;
  logic [7:0]       rx_data;
  logic             rx_par_err, rx_frm_err, rx_valid, rx_ovr, rx_busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    tests, fails, cyc, ovr_cnt, valid_rise_cyc, frame_start_cyc;
  logic  valid_prev = 1'b0;

  uart_rx_core #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
    .mclk            (mclk),
    .reset           (reset),
    .rx_en           (rx_en),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_even_parity (cfg_even_parity),
    .cfg_divisor     (cfg_divisor),
    .rxd             (rxd),
    .rx_data         (rx_data),
    .rx_par_err      (rx_par_err),
    .rx_frm_err      (rx_frm_err),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_ovr          (rx_ovr),
    .rx_busy         (rx_busy)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc++;

  // Record accepted words, overrun pulses and rx_valid rising edges.
  always @(negedge mclk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) obs_q.push_back({rx_data, rx_par_err, rx_frm_err});
      if (rx_ovr) ovr_cnt++;
      if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
    end
    valid_prev = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at cycle %0d, required finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // Expected received word from the bits actually placed on the line.
  function automatic word_t model(input logic [7:0] bits_in, input int nbits, input bit par_en,
                                  input bit even, input logic pbit, input logic s1,
                                  input logic s2, input bit two);
    word_t w;
    int    v;
    int    ones;
    v = 0;
    ones = 0;
    for (int i = 0; i < nbits; i++) if (bits_in[i]) begin v += (1 << i); ones++; end
    if (par_en && pbit) ones++;
    w.d  = 8'(v);
    w.pe = par_en && ((ones % 2) != (even ? 0 : 1));
    w.fe = (s1 == 1'b0) || (two && s2 == 1'b0);
    return w;
  endfunction

  task automatic set_cfg(input int bits, input bit two, input bit par, input bit even, input int div);
    cfg_data_bits   = 2'(bits - 5);
    cfg_stop_bits   = two;
    cfg_parity_en   = par;
    cfg_even_parity = even;
    cfg_divisor     = DIV_W'(div);
  endtask

  // Drive one serial frame on rxd using the current configuration.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit expect_word);
    int   nbits, per, ones;
    bit   par, even, two;
    logic p, s1, s2;
    nbits = int'(cfg_data_bits) + 5;
    per   = 16 * (int'(cfg_divisor) + 1);
    par   = cfg_parity_en;
    even  = cfg_even_parity;
    two   = cfg_stop_bits;
    ones  = 0;
    for (int i = 0; i < nbits; i++) if (d[i]) ones++;
    p  = even ? logic'(ones % 2) : logic'(1 - (ones % 2));
    if (bad_par) p = ~p;
    s1 = bad_stop ? 1'b0 : 1'b1;
    s2 = 1'b1;
    frame_start_cyc = cyc;
    rxd = 1'b0; step(per);
    for (int i = 0; i < nbits; i++) begin rxd = d[i]; step(per); end
    if (par) begin rxd = p; step(per); end
    rxd = s1; step(per);
    if (two) begin rxd = s2; step(per); end
    rxd = 1'b1; step(2);
    if (expect_word) exp_q.push_back(model(d, nbits, par, even, p, s1, s2, two));
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin step(1); k++; end
    step(4);
    ok = (obs_q.size() == n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h exp 00", rx_data); end
    tests++; if ({rx_par_err, rx_frm_err, rx_ovr, rx_busy} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b exp 0000", {rx_par_err, rx_frm_err, rx_ovr, rx_busy});
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_8n1();
    bit    ok;
    int    lat;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(8, 0, 0, 0, 0);
    rx_en = 1'b1; rx_ready = 1'b1;
    step(4);
    send_frame(8'hA5, 0, 0, 1);
    lat = valid_rise_cyc - frame_start_cyc;
    tests++; if (lat < 148 || lat > 164) begin fails++; $display("FAIL 8n1_latency: got %0d clk exp 148..164", lat); end
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 0, 0, 1);
    wait_obs(exp_q.size(), 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL 8n1_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL 8n1_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_7e2();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(7, 1, 1, 1, 0);
    step(4);
    send_frame(8'h35, 0, 0, 1);
    send_frame(8'h35, 1, 0, 1);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), bit'($urandom_range(0, 1)), 0, 1);
    wait_obs(exp_q.size(), 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL 7e2_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL 7e2_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_5o1();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(5, 0, 1, 0, 0);
    step(4);
    send_frame(8'hFF, 0, 0, 1);
    send_frame(8'hFF, 0, 1, 1);
    send_frame(8'($urandom), 0, 0, 1);
    wait_obs(exp_q.size(), 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL 5o1_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL 5o1_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_random_cfg();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      set_cfg(int'($urandom_range(5, 8)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      step(2);
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
    end
    wait_obs(exp_q.size(), 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rand_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL rand_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_overrun();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(8, 0, 0, 0, 0);
    rx_ready = 1'b0;
    step(4);
    ovr_cnt = 0;
    send_frame(8'h11, 0, 0, 1);
    send_frame(8'h22, 0, 0, 0);
    tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      fails++; $display("FAIL ovr_hold: got valid=%b data=%h exp valid=1 data=11", rx_valid, rx_data);
    end
    tests++; if (ovr_cnt != 1) begin fails++; $display("FAIL ovr_pulse: got %0d pulses exp 1", ovr_cnt); end
    rx_ready = 1'b1;
    step(2);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain_valid: got %b exp 0", rx_valid); end
    wait_obs(exp_q.size(), 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovr_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL ovr_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_glitch();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(8, 0, 0, 0, 0);
    step(4);
    rxd = 1'b0; step(4);
    rxd = 1'b1;
    tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b exp 1", rx_busy); end
    step(12);
    tests++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL glitch_idle: got busy=%b valid=%b exp 0 0", rx_busy, rx_valid);
    end
    send_frame(8'h3C, 0, 0, 1);
    wait_obs(exp_q.size(), 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL glitch_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL glitch_word: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_abort();
    bit    ok;
    word_t e, o;
    exp_q.delete(); obs_q.delete();
    set_cfg(8, 0, 0, 0, 3);
    rx_ready = 1'b0;
    step(4);
    send_frame(8'h77, 0, 0, 0);
    rxd = 1'b0; step(64); rxd = 1'b1; step(64); rxd = 1'b0; step(32);
    tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got %b exp 1", rx_busy); end
    reset = 1'b1; step(1);
    tests++; if ({rx_valid, rx_busy, rx_ovr, rx_par_err, rx_frm_err} !== 5'b0 || rx_data !== 8'h00) begin
      fails++; $display("FAIL rst_mid_state: got flags=%b data=%h exp 00000 00",
                        {rx_valid, rx_busy, rx_ovr, rx_par_err, rx_frm_err}, rx_data);
    end
    reset = 1'b0; rxd = 1'b1; step(100);
    send_frame(8'h66, 0, 0, 1);
    rxd = 1'b0; step(64); rxd = 1'b1; step(64); rxd = 1'b0; step(32);
    rx_en = 1'b0; step(1);
    tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL en_abort_busy: got %b exp 0", rx_busy); end
    tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin
      fails++; $display("FAIL en_abort_hold: got valid=%b data=%h exp 1 66", rx_valid, rx_data);
    end
    rxd = 1'b1; step(4); rx_en = 1'b1; step(100);
    rx_ready = 1'b1;
    send_frame(8'h5A, 0, 0, 1);
    wait_obs(exp_q.size(), 600, ok);
    tests++; if (!ok) begin fails++; $display("FAIL abort_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL abort_word: got %h exp %h", o, e); end
    end
  endtask

  initial begin
    tests = 0; fails = 0; ovr_cnt = 0; cyc = 0; valid_rise_cyc = 0; frame_start_cyc = 0;
    reset = 1'b1; rx_en = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    cfg_data_bits = 2'd3; cfg_stop_bits = 1'b0; cfg_parity_en = 1'b0; cfg_even_parity = 1'b0;
    cfg_divisor = '0;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_random_cfg();
    test_overrun();
    test_glitch();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
